// File: rtl/usb_packet_writer.sv
// usb_packet_writer: packs the SIE receive byte stream little-endian into
// 32-bit words for the USB-side write port of the shared packet buffer and
// holds a completed packet (packet_ready/packet_length) until software
// releases it with packet_consumed.
// Optional feature macro: USB_CRC16_CHECK_EN (CRC16 check of DATA packets).
module usb_packet_writer #(
  parameter int BUFFER_SIZE   = 1024,
  parameter int ADDRESS_WIDTH = $clog2(BUFFER_SIZE / 4),
  parameter int LENGTH_WIDTH  = $clog2(BUFFER_SIZE) + 1
) (
  input  logic                     clk48,
  input  logic                     reset,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  input  logic                     packet_end,
  input  logic                     packet_abort,
  input  logic                     packet_consumed,
  output logic [ADDRESS_WIDTH-1:0] buffer_address,
  output logic [31:0]              buffer_write_value,
  output logic                     buffer_write,
  output logic                     packet_ready,
  output logic [LENGTH_WIDTH-1:0]  packet_length,
  output logic                     packet_overflow,
  output logic                     crc_error
);

  localparam logic [LENGTH_WIDTH-1:0] MAX_COUNT = LENGTH_WIDTH'(BUFFER_SIZE);

  typedef enum logic [2:0] {IDLE, RECEIVING, FLUSH, READY, DISCARD} state_t;

  state_t                   state, state_next;
  logic [LENGTH_WIDTH-1:0]  count;
  logic [31:0]              lanes;
  logic                     full_write;
  logic [ADDRESS_WIDTH-1:0] full_address;
  logic [31:0]              full_value;
  logic                     overflow;
  logic                     flush_to_idle;

  logic                     byte_accept;
  logic                     overflow_byte;
  logic                     end_event;
  logic [LENGTH_WIDTH-1:0]  count_after;
  logic                     partial_after;
  logic [1:0]               lane;
  logic                     end_fail;

  // Per-cycle decode of the RECEIVING events; a byte arriving with
  // packet_end is folded in before the end is evaluated.
  always_comb begin
    lane          = count[1:0];
    overflow_byte = (state == RECEIVING) && byte_valid && !packet_abort &&
                    (count == MAX_COUNT);
    byte_accept   = (state == RECEIVING) && byte_valid && !packet_abort &&
                    (count != MAX_COUNT);
    end_event     = (state == RECEIVING) && packet_end && !packet_abort &&
                    !overflow_byte;
    count_after   = byte_accept ? count + LENGTH_WIDTH'(1) : count;
    partial_after = (count_after[1:0] != 2'b00);
  end

`ifdef USB_CRC16_CHECK_EN
  logic [15:0] crc;
  logic [15:0] crc_after;
  logic        is_data;
  logic        crc_error_r;

  // Reflected CRC16 (poly 0xA001), one byte LSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] c_in,
                                           input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {8'h00, b};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  // CRC result including a byte that arrives together with packet_end.
  always_comb begin
    crc_after = byte_accept ? crc_step(crc, byte_data) : crc;
    end_fail  = is_data && ((crc_after != 16'hB001) ||
                            (count_after < LENGTH_WIDTH'(3)));
  end

  // CRC register over the bytes following the PID, plus the error pulse.
  always_ff @(posedge clk48) begin
    if (reset) begin
      crc         <= '1;
      is_data     <= 1'b0;
      crc_error_r <= 1'b0;
    end else begin
      crc_error_r <= end_event && end_fail;
      if (state == IDLE && byte_valid) begin
        crc     <= '1;
        is_data <= (byte_data[1:0] == 2'b11);
      end else if (byte_accept) begin
        crc <= crc_after;
      end
    end
  end

  assign crc_error = crc_error_r;
`else
  assign end_fail  = 1'b0;
  assign crc_error = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk48) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; abort has priority over byte and end strobes.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (byte_valid) state_next = RECEIVING;
      RECEIVING: begin
        if (packet_abort)       state_next = IDLE;
        else if (overflow_byte) state_next = packet_end ? IDLE : DISCARD;
        else if (packet_end) begin
          if (partial_after)    state_next = FLUSH;
          else if (end_fail)    state_next = IDLE;
          else                  state_next = READY;
        end
      end
      FLUSH:     state_next = flush_to_idle ? IDLE : READY;
      READY:     if (packet_consumed) state_next = IDLE;
      DISCARD:   if (packet_end || packet_abort) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Byte packing, full-word write staging, count and overflow tracking.
  always_ff @(posedge clk48) begin
    if (reset) begin
      count         <= '0;
      lanes         <= '0;
      full_write    <= 1'b0;
      full_address  <= '0;
      full_value    <= '0;
      overflow      <= 1'b0;
      flush_to_idle <= 1'b0;
    end else begin
      full_write <= 1'b0;
      unique case (state)
        IDLE: begin
          if (byte_valid) begin
            lanes    <= {24'h000000, byte_data};
            count    <= LENGTH_WIDTH'(1);
            overflow <= 1'b0;
          end
        end
        RECEIVING: begin
          if (byte_accept) begin
            count <= count + LENGTH_WIDTH'(1);
            if (lane == 2'd3) begin
              full_write   <= 1'b1;
              full_address <= count[ADDRESS_WIDTH+1:2];
              full_value   <= {byte_data, lanes[23:0]};
              lanes        <= '0;
            end else begin
              lanes[{lane, 3'b000} +: 8] <= byte_data;
            end
          end
          if (overflow_byte) overflow <= 1'b1;
          if (end_event) flush_to_idle <= end_fail;
        end
        FLUSH:   lanes <= '0;
        default: ;
      endcase
    end
  end

  // Outputs: FLUSH drives the partial word directly, otherwise the staged
  // full-word write appears one cycle after its completing byte.
  always_comb begin
    packet_ready    = (state == READY);
    packet_length   = (state == READY) ? count : '0;
    packet_overflow = overflow;
    if (state == FLUSH) begin
      buffer_write       = 1'b1;
      buffer_address     = count[ADDRESS_WIDTH+1:2];
      buffer_write_value = lanes;
    end else begin
      buffer_write       = full_write;
      buffer_address     = full_address;
      buffer_write_value = full_value;
    end
  end

endmodule
